// File: rtl/trng_source.sv
// trng_source: von Neumann debiased entropy packer with a one-word holding buffer.
// Optional repetition-count health test is built when TRNG_SOURCE_HEALTH_EN is defined.
module trng_source #(
    parameter int TRNG_WIDTH = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  raw_bit,
    input  logic                  raw_valid,
    input  logic                  trng_req,
    output logic [TRNG_WIDTH-1:0] trng_word,
    output logic                  trng_valid,
    output logic                  health_fail
);

    localparam int CW = (TRNG_WIDTH > 2) ? $clog2(TRNG_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TRNG_WIDTH - 1);

    logic                  phase_q, phase_d;
    logic                  first_q, first_d;
    logic [TRNG_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  acc_full_q, acc_full_d;
    logic [TRNG_WIDTH-1:0] held_q, held_d;
    logic                  held_full_q, held_full_d;
    logic [TRNG_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  kill;

    // Out-of-range cutoff is left as an empty marker block
    if (RCT_CUTOFF < 2) begin : g_cutoff_range
    end

`ifdef TRNG_SOURCE_HEALTH_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [RW-1:0] RCT_MAX = RW'(RCT_CUTOFF);

    logic          last_q, last_d;
    logic [RW-1:0] rct_q, rct_d;
    logic          fail_q, fail_d;

    // Repetition counter on raw samples; failure latches until reset
    always_comb begin
        last_d = last_q;
        rct_d  = rct_q;
        fail_d = fail_q;
        if (en && raw_valid) begin
            last_d = raw_bit;
            if (rct_q == '0 || raw_bit != last_q) begin
                rct_d = RW'(1);
            end else if (rct_q != RCT_MAX) begin
                rct_d = rct_q + RW'(1);
            end
            if (rct_d == RCT_MAX) begin
                fail_d = 1'b1;
            end
        end
    end

    // Health-test state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b0;
            rct_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            last_q <= last_d;
            rct_q  <= rct_d;
            fail_q <= fail_d;
        end
    end

    assign kill        = fail_d;
    assign health_fail = fail_q;
`else
    assign kill        = 1'b0;
    assign health_fail = 1'b0;
`endif

    // Debias pairs, pack bits, move words to the buffer and serve requests
    always_comb begin
        logic emit;
        logic hs;
        logic xfer;
        phase_d     = phase_q;
        first_d     = first_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_full_d  = acc_full_q;
        held_d      = held_q;
        held_full_d = held_full_q;
        word_d      = '0;
        valid_d     = 1'b0;
        emit        = 1'b0;
        hs          = 1'b0;
        xfer        = 1'b0;
        if (en) begin
            if (raw_valid) begin
                if (!phase_q) begin
                    first_d = raw_bit;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    emit    = (raw_bit != first_q);
                end
            end
            hs   = trng_req && held_full_q && !valid_q;
            xfer = acc_full_q && (!held_full_q || hs);
            if (emit && !acc_full_q) begin
                acc_d = {acc_q[TRNG_WIDTH-2:0], first_q};
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    acc_full_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (hs) begin
                valid_d     = 1'b1;
                word_d      = held_q;
                held_full_d = 1'b0;
            end
            if (xfer) begin
                held_d      = acc_q;
                held_full_d = 1'b1;
                acc_full_d  = 1'b0;
            end
            if (kill) begin
                acc_d       = '0;
                cnt_d       = '0;
                acc_full_d  = 1'b0;
                held_full_d = 1'b0;
                valid_d     = 1'b0;
                word_d      = '0;
            end
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= 1'b0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_full_q  <= 1'b0;
            held_q      <= '0;
            held_full_q <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_full_q  <= acc_full_d;
            held_q      <= held_d;
            held_full_q <= held_full_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
        end
    end

    assign trng_word  = word_q;
    assign trng_valid = valid_q;

endmodule

// File: tb/tb_trng_source.sv
// tb_trng_source: directed table and sequence checks for trng_source.
// Health-test expectations follow TRNG_SOURCE_HEALTH_EN.
module tb_trng_source;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       trng_req = 1'b0;
    logic [3:0] trng_word;
    logic       trng_valid;
    logic       health_fail;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] last_word = 4'h0;

    always #5 clk = ~clk;

    trng_source #(.TRNG_WIDTH(4), .RCT_CUTOFF(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .trng_req   (trng_req),
        .trng_word  (trng_word),
        .trng_valid (trng_valid),
        .health_fail(health_fail)
    );

    typedef struct {
        logic       en;
        logic       rv;
        logic       rb;
        logic       req;
        logic       ev;
        logic [3:0] ew;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(logic e, logic rv, logic rb, logic rq,
                                logic ev, logic [3:0] ew);
        vec_t v;
        v.en = e; v.rv = rv; v.rb = rb; v.req = rq; v.ev = ev; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic rv, input logic rb,
                       input logic rq);
        @(negedge clk);
        en = e; raw_valid = rv; raw_bit = rb; trng_req = rq;
        @(posedge clk);
        #1;
        if (trng_valid) begin
            pulses++;
            last_word = trng_word;
        end
    endtask

    task automatic pair(input logic a, input logic b, input logic rq);
        cyc(1'b1, 1'b1, a, rq);
        cyc(1'b1, 1'b1, b, rq);
    endtask

    task automatic wait_pulse(input int budget);
        int p0;
        p0 = pulses;
        for (int i = 0; i < budget; i++) begin
            if (pulses == p0) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        en = 1'b0; raw_valid = 1'b0; raw_bit = 1'b0; trng_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] bits;
        logic       exp_fail;
        logic [0:5] seq_v;
        logic [3:0] seq_w[6];
`ifdef TRNG_SOURCE_HEALTH_EN
        exp_fail = 1'b1;
`else
        exp_fail = 1'b0;
`endif

        // reset behaviour
        repeat (2) @(negedge clk);
        chk("rst_valid", trng_valid, 0);
        chk("rst_word", trng_word, 0);
        chk("rst_health", health_fail, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            chk("idle_valid", trng_valid, 0);
        end

        // basic word: pairs 10,11,01,00,10,10 -> 0xB
        do_reset();
        bits = 4'h0;
        tv[0]  = mk(1, 1, 1, 1, 0, 0);
        tv[1]  = mk(1, 1, 0, 1, 0, 0);
        tv[2]  = mk(1, 1, 1, 1, 0, 0);
        tv[3]  = mk(1, 1, 1, 1, 0, 0);
        tv[4]  = mk(1, 1, 0, 1, 0, 0);
        tv[5]  = mk(1, 1, 1, 1, 0, 0);
        tv[6]  = mk(1, 1, 0, 1, 0, 0);
        tv[7]  = mk(1, 1, 0, 1, 0, 0);
        tv[8]  = mk(1, 1, 1, 1, 0, 0);
        tv[9]  = mk(1, 1, 0, 1, 0, 0);
        tv[10] = mk(1, 1, 1, 1, 0, 0);
        tv[11] = mk(1, 1, 0, 1, 0, 0);
        tv[12] = mk(1, 0, 0, 1, 0, 0);
        tv[13] = mk(1, 0, 0, 1, 1, 4'hB);
        tv[14] = mk(1, 0, 0, 1, 0, 0);
        tv[15] = mk(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(tv[i].en, tv[i].rv, tv[i].rb, tv[i].req);
            chk($sformatf("basic_v%0d", i), trng_valid, tv[i].ev);
            chk($sformatf("basic_w%0d", i), trng_word, tv[i].ew);
        end

        // buffer full: two words stored, rest dropped
        do_reset();
        for (int p = 0; p < 16; p++) begin
            if (p >= 4 && p < 8) pair(1'b0, 1'b1, 1'b0);
            else pair(1'b1, 1'b0, 1'b0);
        end
        chk("full_nopulse", pulses, 0);
        seq_v = 6'b101000;
        seq_w[0] = 4'hF; seq_w[1] = 4'h0; seq_w[2] = 4'h0;
        seq_w[3] = 4'h0; seq_w[4] = 4'h0; seq_w[5] = 4'h0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            chk($sformatf("full_v%0d", i), trng_valid, seq_v[i]);
            chk($sformatf("full_w%0d", i), trng_word, seq_w[i]);
        end

        // en freeze mid-word
        do_reset();
        pair(1'b0, 1'b1, 1'b0);
        pair(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i[0], i[1], 1'b1);
            chk("frz_valid", trng_valid, 0);
        end
        pair(1'b1, 1'b0, 1'b0);
        pair(1'b1, 1'b0, 1'b0);
        wait_pulse(8);
        chk("frz_pulses", pulses, 1);
        chk("frz_word", last_word, 4'h7);

        // async reset during the valid pulse
        do_reset();
        pair(1'b1, 1'b0, 1'b1);
        pair(1'b0, 1'b1, 1'b1);
        pair(1'b1, 1'b0, 1'b1);
        pair(1'b0, 1'b1, 1'b1);
        wait_pulse(8);
        chk("ar_seen", trng_valid, 1);
        chk("ar_word", trng_word, 4'hA);
        reset_n = 1'b0;
        #1;
        chk("ar_valid0", trng_valid, 0);
        chk("ar_word0", trng_word, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int p = 0; p < 3; p++) pair(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ar_partial", pulses, 0);
        pair(1'b1, 1'b0, 1'b1);
        wait_pulse(8);
        chk("ar_pulses", pulses, 1);
        chk("ar_newword", last_word, 4'hF);

        // repetition-count health test
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("hlt_7", health_fail, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("hlt_8", health_fail, exp_fail);
        for (int p = 0; p < 4; p++) pair(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("hlt_pulses", pulses, exp_fail ? 0 : 1);
        chk("hlt_sticky", health_fail, exp_fail);
        chk("hlt_word", trng_word, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trng_source.md
# trng_source

Entropy front-end that answers word requests from the downstream random-word assembler. It samples a raw entropy bit stream, removes bias with a von Neumann corrector, and packs the surviving bits into `TRNG_WIDTH`-bit words. It presents each word through a one-entry holding buffer on a `trng_req`/`trng_valid` handshake. It sits between the ring-oscillator sampler and the RNG word assembler.

## Interface
- `TRNG_WIDTH`, 4, width of each delivered word (≥2)
- `RCT_CUTOFF`, 32, repetition-count cutoff for the health test (≥2; used only with the macro)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  block enable; low freezes all state
- `raw_bit`  in  1  raw entropy sample
- `raw_valid`  in  1  `raw_bit` is a new sample this cycle
- `trng_req`  in  1  consumer wants a word; level, held until served
- `trng_word`  out  `TRNG_WIDTH`  delivered word; 0 when `trng_valid` is low
- `trng_valid`  out  1  one-cycle pulse: `trng_word` is valid
- `health_fail`  out  1  sticky health-test failure; tied 0 without the macro

## Operation
- **Reset values:**
  - `trng_word`=0, `trng_valid`=0, `health_fail`=0.
  - Pair phase = first; accumulator count = 0; `acc_full`=0; `held_full`=0; repetition counter = 0.
- **Debiaser, on an edge with `en && raw_valid`:**
  - Phase first: latch `raw_bit` as `first`; phase becomes second.
  - Phase second: phase becomes first. If `raw_bit != first`, emit `first`; otherwise emit nothing (pairs 00 and 11 are discarded).
- **Accumulator:**
  - Each emitted bit shifts in at the LSB (`acc <= {acc[W-2:0], bit}`), so the first bit kept ends up as the MSB.
  - The count increments per emitted bit. When the `TRNG_WIDTH`-th bit enters, `acc_full` is set and the count returns to 0.
  - While `acc_full` is set, emitted bits are dropped. Pairing continues.
- **Transfer:** on any enabled edge with `acc_full` and (`!held_full` or a handshake on this same edge), `acc` moves to the held word, `held_full`=1 and `acc_full`=0.
- **Handshake:**
  - Fires on an enabled edge with `trng_req && held_full && !trng_valid`.
  - On that edge: `trng_valid`<=1, `trng_word`<=held word, `held_full`<=0 (unless refilled by the same-edge transfer).
  - On the next edge: `trng_valid`<=0 and `trng_word`<=0. There is never more than one pulse per two cycles.
- **Request dropped:** if `trng_req` falls before service, the held word stays buffered and no pulse is issued.
- **`en` low:**
  - `trng_valid` and `trng_word` are forced to 0 on the next edge.
  - All other state is held and raw samples are ignored.
  - On return to high, operation resumes from the held state.
- **`reset_n` asserted at any point, including mid-pair or mid-word:** all state clears immediately (asynchronous); partial words are lost.

## Timing
- Handshake latency:
  - `trng_req` high with `held_full` set at edge N → `trng_valid` high for the cycle after edge N only.
  - With `held_full` clear, the pulse comes one edge after the buffer fills.
- Raw-to-buffer latency: the pair completing a word sets `acc_full` at edge N; the transfer to the held word happens at edge N+1.
- Throughput:
  - One word per `TRNG_WIDTH` accepted pairs.
  - Steady state is bounded by the entropy rate, not by the handshake.
- Buffering: up to two complete words in flight (accumulator plus held word). Further bits are lost, never queued.

## Configuration
- Macro `TRNG_SOURCE_HEALTH_EN`.
- **Defined:**
  - A repetition counter counts consecutive identical `raw_bit` values across enabled `raw_valid` edges; it resets to 1 on a change.
  - When the count reaches `RCT_CUTOFF`, `health_fail` goes high on that edge and stays high until reset.
  - While `health_fail` is high: the accumulator, `acc_full` and `held_full` clear and stay clear, `trng_valid` never asserts, and `trng_word`=0.
- **Undefined:** no counter is built, `health_fail` is constant 0, and there is no effect on the datapath.

## Test plan
- **Reset behaviour:** hold `reset_n` low → all outputs 0. Release; feed no samples; hold `trng_req`=1 for 20 cycles → `trng_valid` stays 0.
- **Basic word** (W=4): pairs 10,11,01,00,10,10 with `trng_req`=1 → exactly one `trng_valid` pulse, `trng_word`=4'b1011 (0xB). `trng_word`=0 on every other cycle.
- **Buffer full:**
  - Feed 16 differing pairs with `trng_req`=0. Accepted pairs give 1,1,1,1 / 0,0,0,0 / then drops.
  - Raise `trng_req`: pulses deliver 0xF, then 0x0, then no third pulse until new pairs arrive.
- **`en` freeze:** drop `en` mid-word (2 bits accumulated) for 10 cycles while `raw_valid` toggles → no count change. Re-enable and feed 2 pairs → word = the 2 pre-freeze bits followed by the 2 new bits.
- **Async reset mid-handshake:** assert `reset_n` low in the cycle `trng_valid`=1 → `trng_valid` and `trng_word` drop to 0 immediately. After release, the next word needs 4 fresh pairs.
- **Health test** (`TRNG_SOURCE_HEALTH_EN`, `RCT_CUTOFF`=8): 8 consecutive `raw_bit`=1 samples → `health_fail`=1 on the 8th edge. `trng_valid` then stays 0 despite later good pairs. Without the macro, the same stimulus leaves `health_fail`=0.
